// File: rtl/cursor_controles.sv
// 4x4 grid cursor driven by five debounced pushbuttons, plus a select strobe.
// Moves and selPulse appear DB_CYCLES+2 edges after s1 first samples a held press.
module cursor_controles #(
  parameter int DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnSelect,
  input  logic       en,
  output logic [1:0] posX,
  output logic [1:0] posY,
  output logic       selPulse,
  output logic [1:0] selX,
  output logic [1:0] selY
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  localparam int B_LEFT  = 0;
  localparam int B_RIGHT = 1;
  localparam int B_UP    = 2;
  localparam int B_DOWN  = 3;
  localparam int B_SEL   = 4;

  logic [4:0]    btn_raw;
  logic [4:0]    s1;
  logic [4:0]    s2;
  logic [4:0]    db;
  logic [4:0]    db_q;
  logic [CW-1:0] cnt [5];
  logic [4:0]    press;

  logic          go_left;
  logic          go_right;
  logic          go_up;
  logic          go_down;
  logic          go_sel;
  logic [1:0]    posx_nxt;
  logic [1:0]    posy_nxt;

  assign btn_raw = {btnSelect, btnDown, btnUp, btnRight, btnLeft};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Any sample matching the current level restarts the stability count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < 5; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      db_q <= db;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of the debounced level only; a press held while en is low is lost.
  assign press    = db & ~db_q;
  assign go_left  = en & press[B_LEFT];
  assign go_right = en & press[B_RIGHT];
  assign go_up    = en & press[B_UP];
  assign go_down  = en & press[B_DOWN];
  assign go_sel   = en & press[B_SEL];

  always_comb begin
    posx_nxt = posX;
    posy_nxt = posY;
    case ({go_right, go_left})
      2'b01:   posx_nxt = posX - 2'd1;
      2'b10:   posx_nxt = posX + 2'd1;
      default: posx_nxt = posX;
    endcase
    case ({go_down, go_up})
      2'b01:   posy_nxt = posY - 2'd1;
      2'b10:   posy_nxt = posY + 2'd1;
      default: posy_nxt = posY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      posX     <= '0;
      posY     <= '0;
      selPulse <= 1'b0;
      selX     <= '0;
      selY     <= '0;
    end else begin
      posX     <= posx_nxt;
      posY     <= posy_nxt;
      selPulse <= go_sel;
      if (go_sel) begin
        selX <= posX;
        selY <= posY;
      end
    end
  end

endmodule

// File: tb/tb_cursor_controles.sv
// Directed bench for cursor_controles with DB_CYCLES=4 (press visible 7 edges after drive).
module tb_cursor_controles;

  localparam logic [4:0] LEFT  = 5'b00001;
  localparam logic [4:0] RIGHT = 5'b00010;
  localparam logic [4:0] UP    = 5'b00100;
  localparam logic [4:0] DOWN  = 5'b01000;
  localparam logic [4:0] SEL   = 5'b10000;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] btns;
  logic [1:0] posX;
  logic [1:0] posY;
  logic       selPulse;
  logic [1:0] selX;
  logic [1:0] selY;

  int checks;
  int passed;
  int fails;

  cursor_controles #(.DB_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .btnLeft  (btns[0]),
    .btnRight (btns[1]),
    .btnUp    (btns[2]),
    .btnDown  (btns[3]),
    .btnSelect(btns[4]),
    .en       (en),
    .posX     (posX),
    .posY     (posY),
    .selPulse (selPulse),
    .selX     (selX),
    .selY     (selY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a clean press long enough to register, then release and let db settle back to 0.
  task automatic pulse(input logic [4:0] mask);
    btns = mask;
    step(7);
    btns = '0;
    step(8);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    fails  = 0;
    rst  = 1'b0;
    en   = 1'b1;
    btns = '0;

    // Outputs stay cleared under reset even with every button high.
    btns = '1;
    step(3);
    chk("rst_posX", {2'b0, posX}, 4'd0);
    chk("rst_posY", {2'b0, posY}, 4'd0);
    chk("rst_selX", {2'b0, selX}, 4'd0);
    chk("rst_selY", {2'b0, selY}, 4'd0);
    chk("rst_selPulse", {3'b0, selPulse}, 4'd0);
    btns = '0;
    step(2);
    rst = 1'b1;
    step(1);

    // Held right press: move exactly at edge 6, once.
    btns = RIGHT;
    step(6);
    chk("right_edge5", {2'b0, posX}, 4'd0);
    step(1);
    chk("right_edge6", {2'b0, posX}, 4'd1);
    step(10);
    chk("right_held", {2'b0, posX}, 4'd1);
    btns = '0;
    step(8);
    pulse(RIGHT);
    chk("right_again", {2'b0, posX}, 4'd2);

    // Wrap-around in both axes.
    pulse(RIGHT);
    chk("right_to3", {2'b0, posX}, 4'd3);
    pulse(RIGHT);
    chk("right_wrap", {2'b0, posX}, 4'd0);
    pulse(UP);
    chk("up_wrap", {2'b0, posY}, 4'd3);
    pulse(DOWN);
    chk("down_wrap", {2'b0, posY}, 4'd0);

    // Bouncing down button never reaches DB_CYCLES stable samples.
    for (int i = 0; i < 8; i++) begin
      btns = (i % 2 == 0) ? DOWN : 5'b0;
      step(1);
    end
    btns = '0;
    step(8);
    chk("bounce_posY", {2'b0, posY}, 4'd0);

    // Move to (2,1), then opposing presses and up+select together.
    pulse(RIGHT);
    pulse(RIGHT);
    pulse(DOWN);
    chk("setup_posX", {2'b0, posX}, 4'd2);
    chk("setup_posY", {2'b0, posY}, 4'd1);
    pulse(LEFT | RIGHT);
    chk("lr_cancel", {2'b0, posX}, 4'd2);
    btns = UP | SEL;
    step(6);
    chk("sel_before", {3'b0, selPulse}, 4'd0);
    step(1);
    chk("sel_pulse", {3'b0, selPulse}, 4'd1);
    chk("sel_X", {2'b0, selX}, 4'd2);
    chk("sel_Y_premove", {2'b0, selY}, 4'd1);
    chk("sel_posY_moved", {2'b0, posY}, 4'd0);
    step(1);
    chk("sel_one_cycle", {3'b0, selPulse}, 4'd0);
    chk("sel_X_held", {2'b0, selX}, 4'd2);
    btns = '0;
    step(8);

    // Simultaneous X and Y moves both apply: (2,0) -> (3,1).
    pulse(RIGHT | DOWN);
    chk("xy_posX", {2'b0, posX}, 4'd3);
    chk("xy_posY", {2'b0, posY}, 4'd1);

    // Press during en=0 is dropped; enabling while held does not replay it.
    en = 1'b0;
    btns = RIGHT | SEL;
    step(10);
    chk("en0_posX", {2'b0, posX}, 4'd3);
    en = 1'b1;
    step(5);
    chk("en1_held_posX", {2'b0, posX}, 4'd3);
    chk("en1_held_selX", {2'b0, selX}, 4'd2);
    btns = '0;
    step(8);
    pulse(RIGHT);
    chk("en1_repress", {2'b0, posX}, 4'd0);
    pulse(LEFT);
    chk("left_wrap", {2'b0, posX}, 4'd3);

    // Reset at debounce count 3 of a select press; held across release.
    btns = SEL;
    step(5);
    rst = 1'b0;
    #1;
    chk("midrst_posX", {2'b0, posX}, 4'd0);
    chk("midrst_posY", {2'b0, posY}, 4'd0);
    chk("midrst_selX", {2'b0, selX}, 4'd0);
    chk("midrst_selPulse", {3'b0, selPulse}, 4'd0);
    step(2);
    rst = 1'b1;
    step(6);
    chk("postrst_edge5", {3'b0, selPulse}, 4'd0);
    step(1);
    chk("postrst_sel", {3'b0, selPulse}, 4'd1);
    chk("postrst_selX", {2'b0, selX}, 4'd0);
    chk("postrst_selY", {2'b0, selY}, 4'd0);
    step(1);
    chk("postrst_sel_off", {3'b0, selPulse}, 4'd0);
    btns = '0;
    step(8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
